// File: rtl/lifo_arbiter.sv
// Two-port arbiter that owns the push/read/pop strobes of one shared LIFO.
// Define LIFO_ARB_FIXED_PRIORITY_EN for fixed priority (port 0 wins ties); default is round-robin.
module lifo_arbiter #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req0_valid_i,
  input  logic                  req0_push_i,
  input  logic [DATA_WIDTH-1:0] req0_data_i,
  output logic                  req0_ready_o,
  input  logic                  req1_valid_i,
  input  logic                  req1_push_i,
  input  logic [DATA_WIDTH-1:0] req1_data_i,
  output logic                  req1_ready_o,
  output logic                  resp0_valid_o,
  output logic                  resp0_err_o,
  output logic                  resp1_valid_o,
  output logic                  resp1_err_o,
  output logic [DATA_WIDTH-1:0] resp_data_o,
  output logic                  lifo_push_o,
  output logic                  lifo_pop_o,
  output logic                  lifo_read_o,
  output logic [DATA_WIDTH-1:0] lifo_data_o,
  input  logic [DATA_WIDTH-1:0] lifo_data_i,
  input  logic                  lifo_empty_i,
  input  logic                  lifo_full_i
);

  typedef enum logic [2:0] {IDLE, PUSH, READ, POP, RESP} state_e;

  state_e                  state_q;
  logic                    port_q;
  logic                    push_q;
  logic                    err_q;
  logic [DATA_WIDTH-1:0]   data_q;
  logic [DATA_WIDTH-1:0]   resp_data_q;
`ifndef LIFO_ARB_FIXED_PRIORITY_EN
  logic                    last_q;
`endif

  logic grant1;
  logic accept;
  logic acc_push;

  always_comb begin
    grant1 = 1'b0;
`ifdef LIFO_ARB_FIXED_PRIORITY_EN
    grant1 = !req0_valid_i && req1_valid_i;
`else
    if (req0_valid_i && req1_valid_i) begin
      grant1 = !last_q;
    end else begin
      grant1 = !req0_valid_i && req1_valid_i;
    end
`endif
  end

  // Ready is forced low while reset is held, even though the FSM sits in IDLE.
  assign req0_ready_o = reset && (state_q == IDLE) && req0_valid_i && !grant1;
  assign req1_ready_o = reset && (state_q == IDLE) && req1_valid_i && grant1;
  assign accept       = req0_ready_o || req1_ready_o;
  assign acc_push     = grant1 ? req1_push_i : req0_push_i;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      port_q      <= 1'b0;
      push_q      <= 1'b0;
      err_q       <= 1'b0;
      data_q      <= '0;
      resp_data_q <= '0;
`ifndef LIFO_ARB_FIXED_PRIORITY_EN
      last_q      <= 1'b1;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            port_q  <= grant1;
            push_q  <= acc_push;
            data_q  <= grant1 ? req1_data_i : req0_data_i;
            err_q   <= 1'b0;
`ifndef LIFO_ARB_FIXED_PRIORITY_EN
            last_q  <= grant1;
`endif
            state_q <= acc_push ? PUSH : READ;
          end
        end
        PUSH: begin
          err_q       <= lifo_full_i;
          resp_data_q <= '0;
          state_q     <= RESP;
        end
        READ: begin
          // Empty is judged here, not at acceptance, so a pop from empty skips POP.
          if (lifo_empty_i) begin
            err_q       <= 1'b1;
            resp_data_q <= '0;
            state_q     <= RESP;
          end else begin
            err_q   <= 1'b0;
            state_q <= POP;
          end
        end
        POP: begin
          resp_data_q <= lifo_data_i;
          state_q     <= RESP;
        end
        RESP: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign lifo_push_o   = (state_q == PUSH) && !lifo_full_i;
  assign lifo_read_o   = (state_q == READ) && !lifo_empty_i;
  assign lifo_pop_o    = (state_q == POP);
  assign lifo_data_o   = data_q;

  assign resp0_valid_o = (state_q == RESP) && !port_q;
  assign resp1_valid_o = (state_q == RESP) && port_q;
  assign resp0_err_o   = resp0_valid_o && err_q;
  assign resp1_err_o   = resp1_valid_o && err_q;
  assign resp_data_o   = resp_data_q;

  logic unused_push;
  assign unused_push = push_q;

endmodule
